// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the round-robin FIFO drain arbiter.
// State encoding, index width and wrap-around pointer arithmetic.
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    CAP,
    OUT
  } state_t;

  localparam int unsigned STAT_W = 32;

  function automatic int unsigned idx_w(
    input int unsigned n
  );
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned rr_next(
    input int unsigned idx,
    input int unsigned n
  );
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/fifo_rr_drain_arbiter_if.sv
// Output stream bundle of the drain arbiter.
// Master drives data/valid/id/last, slave returns ready.
interface fifo_rr_drain_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int N_SRC      = 4
) ();

  localparam int IW = idx_w(N_SRC);

  logic [DATA_WIDTH-1:0] m_tdata;
  logic                  m_tvalid;
  logic                  m_tready;
  logic [IW-1:0]         m_tid;
  logic                  m_tlast;

  modport master (
    output m_tdata,
    output m_tvalid,
    output m_tid,
    output m_tlast,
    input  m_tready
  );

  modport slave (
    input  m_tdata,
    input  m_tvalid,
    input  m_tid,
    input  m_tlast,
    output m_tready
  );

endinterface

// File: rtl/fifo_rr_drain_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set req bit
// searching ptr+1, ptr+2, ... with wrap modulo N_SRC.
module rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int N_SRC = 4,
  localparam int IW    = idx_w(N_SRC)
) (
  input  logic [N_SRC-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [IW-1:0]    gnt_idx,
  output logic             any_req
);

  int unsigned idx;
  logic        found;

  // walk the ring once starting after the last winner
  always_comb begin
    idx     = int'(ptr);
    found   = 1'b0;
    gnt_idx = '0;
    any_req = |req;
    for (int i = 0; i < N_SRC; i++) begin
      idx = rr_next(idx, N_SRC);
      if (!found && req[idx]) begin
        gnt_idx = IW'(idx);
        found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_rr_drain_arbiter.sv
// Round-robin drain of N_SRC read FIFOs onto one stream.
// Optional per-source word counters: FIFO_ARB_STATS_EN.
module fifo_rr_drain_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int N_SRC      = 4,
  parameter int MAX_BURST  = 8
) (
  input  logic                        clk,
  input  logic                        nrst,
  input  logic [N_SRC*DATA_WIDTH-1:0] src_rdata,
  input  logic [N_SRC-1:0]            src_empty,
  output logic [N_SRC-1:0]            src_rena,
`ifdef FIFO_ARB_STATS_EN
  output logic [N_SRC*STAT_W-1:0]     stat_words,
  input  logic                        stat_clr,
`endif
  fifo_rr_drain_arbiter_if.master     m
);

  localparam int IW = idx_w(N_SRC);
  localparam int BW = $clog2(MAX_BURST) + 1;
  localparam logic [BW-1:0] LAST_CNT =
    BW'(MAX_BURST - 1);

  state_t                state_q, state_d;
  logic [IW-1:0]         grant_q, grant_d;
  logic [IW-1:0]         rr_q, rr_d;
  logic [BW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic [IW-1:0]         tid_q, tid_d;
  logic                  tvalid_q, tvalid_d;
  logic                  tlast_q, tlast_d;
  logic [N_SRC-1:0]      req;
  logic [IW-1:0]         arb_idx;
  logic                  any_req;
  logic                  hs;

  assign req = ~src_empty;
  assign hs  = tvalid_q & m.m_tready;

  rr_arbiter #(
    .N_SRC (N_SRC)
  ) u_arb (
    .req     (req),
    .ptr     (rr_q),
    .gnt_idx (arb_idx),
    .any_req (any_req)
  );

  // next-state and datapath for grant/read/capture/offer
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_d     = rr_q;
    cnt_d    = cnt_q;
    tdata_d  = tdata_q;
    tid_d    = tid_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    src_rena = '0;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_d = arb_idx;
          cnt_d   = '0;
          state_d = RD;
        end
      end
      RD: begin
        src_rena[grant_q] = 1'b1;
        state_d           = CAP;
      end
      CAP: begin
        tdata_d  = src_rdata[int'(grant_q)*DATA_WIDTH
                             +: DATA_WIDTH];
        tid_d    = grant_q;
        tvalid_d = 1'b1;
        tlast_d  = (cnt_q == LAST_CNT) |
                   src_empty[grant_q];
        cnt_d    = cnt_q + BW'(1);
        state_d  = OUT;
      end
      OUT: begin
        if (hs) begin
          tvalid_d = 1'b0;
          if (tlast_q) begin
            rr_d    = grant_q;
            state_d = IDLE;
          end else begin
            state_d = RD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state and output registers, synchronous reset
  always_ff @(posedge clk) begin
    if (nrst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_q     <= IW'(N_SRC - 1);
      cnt_q    <= '0;
      tdata_q  <= '0;
      tid_q    <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_q     <= rr_d;
      cnt_q    <= cnt_d;
      tdata_q  <= tdata_d;
      tid_q    <= tid_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
    end
  end

  assign m.m_tdata  = tdata_q;
  assign m.m_tvalid = tvalid_q;
  assign m.m_tid    = tid_q;
  assign m.m_tlast  = tlast_q;

`ifdef FIFO_ARB_STATS_EN
  logic [N_SRC-1:0][STAT_W-1:0] stat_q;

  // per-source transfer counters, clear beats increment
  always_ff @(posedge clk) begin
    if (nrst || stat_clr) begin
      stat_q <= '0;
    end else if (hs) begin
      stat_q[tid_q] <= stat_q[tid_q] + STAT_W'(1);
    end
  end

  assign stat_words = stat_q;
`endif

endmodule

// File: tb/tb_fifo_rr_drain_arbiter.sv
// Scoreboard bench for fifo_rr_drain_arbiter.
// Build with FIFO_ARB_STATS_EN to also cover counters.
module tb_fifo_rr_drain_arbiter;

  localparam int DW = 32;
  localparam int NS = 4;

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  id;
    logic        last;
  } exp_t;

  logic           clk;
  logic           nrst;
  logic [127:0]   src_rdata;
  logic [3:0]     src_empty;
  logic [3:0]     src_rena;
`ifdef FIFO_ARB_STATS_EN
  logic [127:0]   stat_words;
  logic           stat_clr;
`endif

  fifo_rr_drain_arbiter_if #(
    .DATA_WIDTH (DW),
    .N_SRC      (NS)
  ) mif ();

  fifo_rr_drain_arbiter #(
    .DATA_WIDTH (DW),
    .N_SRC      (NS),
    .MAX_BURST  (8)
  ) dut (
    .clk        (clk),
    .nrst       (nrst),
    .src_rdata  (src_rdata),
    .src_empty  (src_empty),
    .src_rena   (src_rena),
`ifdef FIFO_ARB_STATS_EN
    .stat_words (stat_words),
    .stat_clr   (stat_clr),
`endif
    .m          (mif.master)
  );

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];
  logic [31:0] fq [4][$];
  int   rena_cnt [4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string        name,
    input logic [127:0] act,
    input logic [127:0] req
  );
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, req);
    end
  endtask

  // FIFO model: pop on rena, empty reflects the pop
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (src_rena[i]) begin
        rena_cnt[i]++;
        if (fq[i].size() > 0)
          src_rdata[i*32 +: 32] = fq[i].pop_front();
      end
      src_empty[i] = (fq[i].size() == 0);
    end
  end

  // scoreboard monitor on each handshake
  always @(negedge clk) begin
    exp_t e;
    if (!nrst && mif.m_tvalid && mif.m_tready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word", 1'b1, 1'b0);
      end else begin
        e = exp_q.pop_front();
        chk("out_word",
            {mif.m_tdata, mif.m_tid, mif.m_tlast},
            {e.d, e.id, e.last});
      end
    end
  end

  task automatic load(
    input int          i,
    input logic [31:0] d
  );
    fq[i].push_back(d);
  endtask

  task automatic expect_w(
    input logic [31:0] d,
    input logic [1:0]  id,
    input logic        last
  );
    exp_q.push_back('{d: d, id: id, last: last});
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cyc();
    nrst = 1'b1;
    cyc();
    nrst = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0) break;
      cyc();
    end
    chk("drain_done", 32'(exp_q.size()), 32'd0);
    repeat (4) cyc();
  endtask

  task automatic wait_valid(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (mif.m_tvalid) break;
      cyc();
    end
    chk("valid_seen", mif.m_tvalid, 1'b1);
  endtask

  initial begin
    int          s;
    logic [34:0] snap;
    nrst          = 1'b1;
    mif.m_tready  = 1'b0;
    src_rdata     = '0;
    src_empty     = '1;
    for (int i = 0; i < 4; i++) rena_cnt[i] = 0;
`ifdef FIFO_ARB_STATS_EN
    stat_clr = 1'b0;
`endif
    repeat (3) cyc();
    chk("reset_outs",
        {src_rena, mif.m_tvalid, mif.m_tdata,
         mif.m_tid, mif.m_tlast},
        '0);
    nrst = 1'b0;

    // single source, three words, latency
    mif.m_tready = 1'b1;
    s = rena_cnt[0];
    for (int k = 0; k < 3; k++) begin
      load(0, 32'hA000_0000 + k);
      expect_w(32'hA000_0000 + k, 2'd0, k == 2);
    end
    cyc();
    chk("first_rena", src_rena, 4'b0001);
    cyc();
    chk("valid_lat2", mif.m_tvalid, 1'b0);
    cyc();
    chk("valid_lat3", mif.m_tvalid, 1'b1);
    wait_drain(100);
    chk("rena_cnt0", 32'(rena_cnt[0] - s), 32'd3);
    chk("idle_quiet", {src_rena, mif.m_tvalid}, '0);

    // two sources, bursts capped at 8
    do_reset();
    for (int k = 0; k < 10; k++) begin
      load(0, 32'h0000_0100 + k);
      load(2, 32'h0002_0100 + k);
    end
    for (int k = 0; k < 8; k++)
      expect_w(32'h0000_0100 + k, 2'd0, k == 7);
    for (int k = 0; k < 8; k++)
      expect_w(32'h0002_0100 + k, 2'd2, k == 7);
    for (int k = 8; k < 10; k++)
      expect_w(32'h0000_0100 + k, 2'd0, k == 9);
    for (int k = 8; k < 10; k++)
      expect_w(32'h0002_0100 + k, 2'd2, k == 9);
    wait_drain(400);

    // backpressure: hold stable, single rena
    mif.m_tready = 1'b0;
    do_reset();
    s = rena_cnt[1];
    load(1, 32'hB000_0000);
    load(1, 32'hB000_0001);
    expect_w(32'hB000_0000, 2'd1, 1'b0);
    expect_w(32'hB000_0001, 2'd1, 1'b1);
    wait_valid(20);
    snap = {mif.m_tdata, mif.m_tid, mif.m_tlast};
    for (int k = 0; k < 20; k++) begin
      cyc();
      chk("stall_hold",
          {mif.m_tvalid, mif.m_tdata,
           mif.m_tid, mif.m_tlast},
          {1'b1, snap});
    end
    chk("stall_rena", 32'(rena_cnt[1] - s), 32'd1);
    mif.m_tready = 1'b1;
    wait_drain(100);

    // rotation after grant to src1
    do_reset();
    load(1, 32'hC1);
    expect_w(32'hC1, 2'd1, 1'b1);
    wait_drain(100);
    for (int i = 0; i < 4; i++) load(i, 32'h40 + i);
    expect_w(32'h42, 2'd2, 1'b1);
    expect_w(32'h43, 2'd3, 1'b1);
    expect_w(32'h40, 2'd0, 1'b1);
    expect_w(32'h41, 2'd1, 1'b1);
    wait_drain(200);

    // reset in OUT drops the pending word
    mif.m_tready = 1'b0;
    do_reset();
    for (int k = 0; k < 3; k++)
      load(0, 32'hD000_0000 + k);
    wait_valid(20);
    nrst = 1'b1;
    cyc();
    chk("rst_mid_outs",
        {src_rena, mif.m_tvalid, mif.m_tdata,
         mif.m_tid, mif.m_tlast},
        '0);
    load(3, 32'hE000_0000);
    expect_w(32'hD000_0001, 2'd0, 1'b0);
    expect_w(32'hD000_0002, 2'd0, 1'b1);
    expect_w(32'hE000_0000, 2'd3, 1'b1);
    nrst = 1'b0;
    mif.m_tready = 1'b1;
    wait_drain(200);

`ifdef FIFO_ARB_STATS_EN
    do_reset();
    for (int k = 0; k < 5; k++) begin
      load(1, 32'hF100_0000 + k);
      expect_w(32'hF100_0000 + k, 2'd1, k == 4);
    end
    for (int k = 0; k < 3; k++) begin
      load(3, 32'hF300_0000 + k);
      expect_w(32'hF300_0000 + k, 2'd3, k == 2);
    end
    wait_drain(300);
    chk("stat_words", stat_words,
        {32'd3, 32'd0, 32'd5, 32'd0});
    stat_clr = 1'b1;
    cyc();
    chk("stat_clr", stat_words, '0);
    stat_clr = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/fifo_rr_drain_arbiter.md
Name: fifo_rr_drain_arbiter

Overview:
- Round-robin scheduler that drains N read-side FIFO ports onto one valid/ready output stream.
- Grants one non-empty FIFO at a time and issues its rena pulses.
- Captures rdata one cycle after each read.
- Holds the grant for a burst of up to MAX_BURST words, then rotates.
- Sits between the per-channel FIFOs and the shared downstream consumer (DMA/packer).

Parameters:
- DATA_WIDTH, 32, FIFO and output data width.
- N_SRC, 4, number of source FIFOs (2..16).
- MAX_BURST, 8, maximum words per grant (1..256).

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- nrst  in  1  synchronous reset, active-high: 1 = reset, sampled on the rising edge of clk.
- src_rdata  in  N_SRC*DATA_WIDTH  FIFO read data; slice i = FIFO i. Valid the cycle after rena.
- src_empty  in  N_SRC  FIFO empty flags.
- src_rena  out  N_SRC  read enables; at most one bit set, one-cycle pulses.
- m_tdata  out  DATA_WIDTH  output word.
- m_tvalid  out  1  output valid.
- m_tready  in  1  downstream ready.
- m_tid  out  clog2(N_SRC)  source index of m_tdata.
- m_tlast  out  1  marks the last word of the current burst.

Behaviour:
- Reset values: src_rena=0, m_tvalid=0, m_tdata=0, m_tid=0, m_tlast=0, state=IDLE, burst_cnt=0, rr_ptr=N_SRC-1, so source 0 has first priority.
- FIFO contract: a rena pulse at edge k pops the word. src_rdata is valid during cycle k+1. src_empty seen in cycle k+1 already reflects the pop.
- States:
  - IDLE:
    - If any src_empty bit is 0, pick the first non-empty source searching rr_ptr+1, rr_ptr+2, ... with wrap mod N_SRC.
    - Latch it as grant, clear burst_cnt, go to RD.
    - If all sources are empty, stay in IDLE.
  - RD:
    - src_rena[grant]=1 for exactly this cycle, then go to CAP.
    - RD is entered only when src_empty[grant]=0, so a read never hits an empty FIFO.
  - CAP:
    - Register m_tdata=src_rdata[grant], m_tid=grant, m_tvalid=1.
    - m_tlast = (burst_cnt==MAX_BURST-1) or src_empty[grant].
    - burst_cnt++, go to OUT.
  - OUT:
    - Hold m_tdata, m_tid, m_tlast and m_tvalid stable until m_tready=1.
    - On handshake (m_tvalid & m_tready): m_tvalid=0 next cycle.
    - If m_tlast=0, go to RD with the same grant.
    - If m_tlast=1, set rr_ptr=grant and go to IDLE.
- Throughput: 1 word per 3 cycles when m_tready is held high. A new grant adds 1 IDLE cycle.
- Latency: first non-empty flag seen in IDLE -> m_tvalid high 3 cycles later (IDLE->RD->CAP, valid in OUT).
- Boundary conditions:
  - Another source becoming non-empty mid-burst does not preempt the current grant.
  - A granted FIFO refilling after its m_tlast word was captured does not extend the burst; the burst still ends.
  - If rr_ptr+1 is empty, the search skips it without a wasted cycle.
  - With a single active source, the block re-grants the same source after its IDLE cycle.
  - m_tready asserted while m_tvalid=0 has no effect.
  - nrst mid-burst: return to reset values next edge. Any word captured but not transferred is dropped, and src_rena is forced to 0.
- Width rules:
  - burst_cnt width = clog2(MAX_BURST)+1, no wrap.
  - rr_ptr wraps mod N_SRC, including for non-power-of-2 N_SRC.

Optional Feature:
- Macro: FIFO_ARB_STATS_EN.
- When defined, adds port stat_words out N_SRC*32, one word counter per source.
  - Counter i increments on each handshake with m_tid==i.
  - Wraps at 2^32 and resets to 0.
  - Adds port stat_clr in 1: synchronous clear of all counters. If clear and increment hit the same cycle, the clear wins.
- When not defined, neither port exists and no counter logic is present.

Decomposition:
- Package fifo_arb_pkg:
  - State enum {IDLE, RD, CAP, OUT}.
  - Helper function for the next round-robin index with wrap.
  - Width constant for clog2.
- Sub-module rr_arbiter: combinational. Inputs req[N_SRC] and ptr; outputs gnt_idx and any_req. Searches from ptr+1 with wrap.

Test Plan:
- Reset, then FIFO0 holds 3 words A0..A2, others empty, m_tready=1:
  - 3 rena pulses on bit 0.
  - Output A0, A1, A2 with m_tid=0.
  - m_tlast only on A2.
  - Then IDLE with rena=0.
- FIFO0 and FIFO2 each hold 10 words, MAX_BURST=8:
  - Order: 8 from src0 (tlast on the 8th), 8 from src2, 2 from src0, 2 from src2.
  - tlast closes every burst.
- m_tready=0 for 20 cycles with a word pending:
  - m_tdata, m_tid and m_tlast stay stable.
  - Exactly one rena was issued.
  - No further rena until the handshake.
- All 4 FIFOs hold 1 word each, rr_ptr=1 after a grant to src1:
  - Next grant order: 2, 3, 0, 1.
  - m_tlast=1 on every word.
- nrst asserted in OUT state mid-burst:
  - Next cycle m_tvalid=0 and src_rena=0.
  - After release, src0 is granted first.
- FIFO_ARB_STATS_EN: transfer 5 words from src1 and 3 from src3:
  - stat_words = {3, 0, 5, 0} for sources 3..0.
  - stat_clr -> all counters 0 next cycle.
